// File: rtl/clk_sel_pkg.sv
// Shared types and constants for the clka/clkb select controller.
// Build option CLK_SEL_SWCNT_EN adds the completed-switch counter.
package clk_sel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  localparam logic SEL_CLKA = 1'b0;
  localparam logic SEL_CLKB = 1'b1;

endpackage

// File: rtl/clk_sel_ctrl_if.sv
// Request handshake and mux-select bundle for clk_sel_ctrl.
// sw_count exists only when CLK_SEL_SWCNT_EN is defined.
interface clk_sel_ctrl_if;

  logic req_valid;
  logic req_sel;
  logic req_ready;
  logic sel_clkb;
  logic busy;
  logic done;
`ifdef CLK_SEL_SWCNT_EN
  logic [15:0] sw_count;

  modport master (
    output req_valid, req_sel,
    input  req_ready, sel_clkb, busy, done, sw_count
  );

  modport slave (
    input  req_valid, req_sel,
    output req_ready, sel_clkb, busy, done, sw_count
  );
`else

  modport master (
    output req_valid, req_sel,
    input  req_ready, sel_clkb, busy, done
  );

  modport slave (
    input  req_valid, req_sel,
    output req_ready, sel_clkb, busy, done
  );
`endif

endinterface

// File: rtl/clk_sel_dly_cnt.sv
// Loadable down-counter with terminal-count flag.
// Stops at zero instead of wrapping.
module clk_sel_dly_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/clk_sel_ctrl.sv
// Clock-select controller: handshake in, registered mux select out.
// Define CLK_SEL_SWCNT_EN to add the saturating sw_count output.
module clk_sel_ctrl
  import clk_sel_pkg::*;
#(
  parameter logic        RST_SEL    = SEL_CLKB,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned HOLD_CYC   = 64,
  parameter int unsigned CNT_W      = 8
) (
  input logic           clk,
  input logic           rst,
  clk_sel_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] SETTLE_LD =
    CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD =
    (HOLD_CYC == 0) ? '0 : CNT_W'(HOLD_CYC - 1);
  localparam logic SETTLE_ONE = (SETTLE_CYC == 1);

  state_e           state_q;
  state_e           state_d;
  logic             sel_q;
  logic             sel_d;
  logic             busy_q;
  logic             done_q;
  logic             done_d;
  logic             accept;
  logic             same;
  logic             ld;
  logic             tc;
  logic [CNT_W-1:0] ld_val;
  logic [CNT_W-1:0] cnt;

  clk_sel_dly_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (ld),
    .val_i  (ld_val),
    .cnt_o  (cnt),
    .tc_o   (tc)
  );

  assign accept = bus.req_valid && (state_q == ST_IDLE);
  assign same   = (bus.req_sel == sel_q);

  // Counter is preloaded while idle so SETTLE starts counting on entry.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    ld      = 1'b0;
    ld_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        ld     = 1'b1;
        ld_val = SETTLE_LD;
        if (accept) begin
          if (same) begin
            done_d = 1'b1;
          end else begin
            sel_d   = bus.req_sel;
            state_d = ST_SETTLE;
            done_d  = SETTLE_ONE;
          end
        end
      end
      ST_SETTLE: begin
        done_d = (cnt == CNT_W'(1));
        if (tc) begin
          ld      = 1'b1;
          ld_val  = HOLD_LD;
          state_d = (HOLD_CYC == 0) ? ST_IDLE : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tc) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= RST_SEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.sel_clkb  = sel_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef CLK_SEL_SWCNT_EN
  logic [15:0] swc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      swc_q <= '0;
    end else if ((state_q == ST_SETTLE) && tc &&
                 (swc_q != 16'hFFFF)) begin
      swc_q <= swc_q + 16'd1;
    end
  end

  assign bus.sw_count = swc_q;
`endif

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Directed bench for clk_sel_ctrl: default unit plus a
// SETTLE_CYC=4/HOLD_CYC=0 unit for back-to-back acceptance.
module tb_clk_sel_ctrl;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks   = 0;
  int   failures = 0;

  clk_sel_ctrl_if ia ();
  clk_sel_ctrl_if ib ();

  always #5 clk = ~clk;

  clk_sel_ctrl u_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ia)
  );

  clk_sel_ctrl #(
    .SETTLE_CYC (4),
    .HOLD_CYC   (0)
  ) u_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ib)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy_a(input string tag);
    int n;
    n = 0;
    while (ia.req_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, ia.req_ready, 1);
  endtask

  task automatic wait_rdy_b(input string tag);
    int n;
    n = 0;
    while (ib.req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk(tag, ib.req_ready, 1);
  endtask

  initial begin
    int dn;
    bit ok;
    rst_a = 1'b1;
    rst_b = 1'b1;
    ia.req_valid = 1'b0;
    ia.req_sel   = 1'b0;
    ib.req_valid = 1'b0;
    ib.req_sel   = 1'b0;
    tick();
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();

    chk("rst_sel", ia.sel_clkb, 1);
    chk("rst_rdy", ia.req_ready, 1);
    chk("rst_busy", ia.busy, 0);
    chk("rst_done", ia.done, 0);
`ifdef CLK_SEL_SWCNT_EN
    chk("rst_swc", ia.sw_count, 0);
`endif

    // real switch to clka
    ia.req_valid = 1'b1;
    ia.req_sel   = 1'b0;
    tick();
    ia.req_valid = 1'b0;
    chk("sw_sel1", ia.sel_clkb, 0);
    chk("sw_busy1", ia.busy, 1);
    chk("sw_rdy1", ia.req_ready, 0);
    dn = 0;
    ok = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      if (k > 1) tick();
      if (ia.done === 1'b1) dn++;
      if (k == 16) chk("sw_done16", ia.done, 1);
      if (ia.req_ready !== 1'b0) ok = 1'b0;
    end
    chk("sw_rdy_low80", ok, 1);
    tick();
    chk("sw_rdy81", ia.req_ready, 1);
    chk("sw_busy81", ia.busy, 0);
    chk("sw_done_cnt", dn, 1);

    // same-select request, then immediate re-accept
    ia.req_valid = 1'b1;
    ia.req_sel   = 1'b0;
    tick();
    chk("same_done", ia.done, 1);
    chk("same_sel", ia.sel_clkb, 0);
    chk("same_busy", ia.busy, 0);
    chk("same_rdy", ia.req_ready, 1);
    tick();
    ia.req_valid = 1'b0;
    chk("same_done2", ia.done, 1);
    tick();
    chk("same_done_off", ia.done, 0);

    // held valid with toggling req_sel while not ready
    ia.req_valid = 1'b1;
    ia.req_sel   = 1'b1;
    tick();
    chk("hold_sel1", ia.sel_clkb, 1);
    ok = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      if (k > 1) tick();
      ia.req_sel = k[0];
      if (ia.sel_clkb !== 1'b1 || ia.req_ready !== 1'b0)
        ok = 1'b0;
    end
    chk("hold_nochg", ok, 1);
    tick();
    ia.req_sel = 1'b0;
    chk("hold_rdy", ia.req_ready, 1);
    chk("hold_sel_pre", ia.sel_clkb, 1);
    tick();
    ia.req_valid = 1'b0;
    chk("hold_acc", ia.sel_clkb, 0);
    wait_rdy_a("hold_idle");

    // back to clkb, then abort a switch to clka
    ia.req_valid = 1'b1;
    ia.req_sel   = 1'b1;
    tick();
    ia.req_valid = 1'b0;
    wait_rdy_a("abort_pre_idle");
    chk("abort_pre_sel", ia.sel_clkb, 1);
    ia.req_valid = 1'b1;
    ia.req_sel   = 1'b0;
    tick();
    ia.req_valid = 1'b0;
    chk("abort_sel0", ia.sel_clkb, 0);
    repeat (4) tick();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("abort_sel", ia.sel_clkb, 1);
    chk("abort_rdy", ia.req_ready, 1);
    chk("abort_busy", ia.busy, 0);
    chk("abort_done", ia.done, 0);
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ia.done !== 1'b0 || ia.busy !== 1'b0) ok = 1'b0;
    end
    chk("abort_quiet", ok, 1);

    // unit B: SETTLE_CYC=4, HOLD_CYC=0
    ib.req_valid = 1'b1;
    ib.req_sel   = 1'b0;
    tick();
    chk("b_sel0", ib.sel_clkb, 0);
    ib.req_sel = 1'b1;
    tick();
    tick();
    tick();
    chk("b_done4", ib.done, 1);
    chk("b_rdy4", ib.req_ready, 0);
    tick();
    chk("b_rdy5", ib.req_ready, 1);
    chk("b_sel5", ib.sel_clkb, 0);
    tick();
    ib.req_valid = 1'b0;
    chk("b_b2b_sel", ib.sel_clkb, 1);
    chk("b_b2b_busy", ib.busy, 1);
    wait_rdy_b("b_idle1");
    ib.req_valid = 1'b1;
    ib.req_sel   = 1'b1;
    tick();
    chk("b_same1", ib.done, 1);
    tick();
    chk("b_same2", ib.done, 1);
    ib.req_sel = 1'b0;
    tick();
    ib.req_valid = 1'b0;
    chk("b_sw3_sel", ib.sel_clkb, 0);
    wait_rdy_b("b_idle2");
    tick();
`ifdef CLK_SEL_SWCNT_EN
    chk("b_swc", ib.sw_count, 3);
`endif
    chk("b_final_sel", ib.sel_clkb, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
